// File: rtl/sram_ctrl_pkg.sv
// Shared types for the SRAM request/response front end: FSM states and
// the classification of an accepted request.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    MERGE = 2'd2,
    RSP   = 2'd3
  } sram_ctrl_state_e;

  typedef enum logic [1:0] {
    RD   = 2'd0,
    FULL = 2'd1,
    PART = 2'd2,
    NOP  = 2'd3
  } sram_req_cls_e;

endpackage

// File: rtl/sram_rw_if_t.sv
// Word-wide single-port SRAM command port: the master drives one command per
// cycle, the slave returns read data one cycle after a read command.
interface sram_rw_if_t #(
  parameter int AW = 15,
  parameter int DW = 32
);
  logic          cs;
  logic          wen;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;

  modport mst (output cs, output wen, output addr, output wdata, input rdata);
  modport slv (input cs, input wen, input addr, input wdata, output rdata);
endinterface

// File: rtl/sram_byte_merge.sv
// Byte-lane merge for read-modify-write: strobed lanes take the new word,
// the rest keep the word read from the SRAM.
module sram_byte_merge #(
  parameter int DW = 32
) (
  input  logic [DW-1:0]   old_word,
  input  logic [DW-1:0]   new_word,
  input  logic [DW/8-1:0] strb,
  output logic [DW-1:0]   merged
);

  always_comb begin
    merged = old_word;
    for (int i = 0; i < DW/8; i++) begin
      if (strb[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
  end

endmodule

// File: rtl/sram_ctrl.sv
// Single-outstanding byte-addressed request front end for a word SRAM;
// partial writes are carried out as read-modify-write.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int AW = 15,
  parameter int DW = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_vld,
  output logic                        req_rdy,
  input  logic [AW+$clog2(DW/8)-1:0]  req_addr,
  input  logic                        req_wen,
  input  logic [DW/8-1:0]             req_wstrb,
  input  logic [DW-1:0]               req_wdata,
  output logic                        rsp_vld,
  input  logic                        rsp_rdy,
  output logic [DW-1:0]               rsp_rdata,
  sram_rw_if_t.mst                    sram_rw_mst
);

  localparam int BW = DW/8;
  localparam int OW = $clog2(BW);

  sram_ctrl_state_e state;
  sram_req_cls_e    cls_p0;
  sram_req_cls_e    next_cls;
  logic [BW-1:0]    req_strb_p0;
  logic [DW-1:0]    req_wdata_p0;
  logic             cs_q;
  logic             wen_q;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    wdata_q;
  logic [DW-1:0]    merged;
  logic             addr_lsb_unused;

  assign addr_lsb_unused = ^req_addr[OW-1:0];

  always_comb begin
    if (!req_wen)        next_cls = RD;
    else if (&req_wstrb) next_cls = FULL;
    else if (|req_wstrb) next_cls = PART;
    else                 next_cls = NOP;
  end

  // Request capture (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (state == IDLE && req_vld) begin
      req_strb_p0  <= req_wstrb;
      req_wdata_p0 <= req_wdata;
    end
  end

  sram_byte_merge #(.DW(DW)) u_merge (
    .old_word (sram_rw_mst.rdata),
    .new_word (req_wdata_p0),
    .strb     (req_strb_p0),
    .merged   (merged)
  );

  // FSM and registered SRAM command; the command for CMD is loaded at accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cls_p0  <= RD;
      cs_q    <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_vld) begin
            state  <= CMD;
            cls_p0 <= next_cls;
            cs_q   <= (next_cls != NOP);
            wen_q  <= (next_cls == FULL);
            if (next_cls != NOP) addr_q  <= req_addr[AW+OW-1:OW];
            if (next_cls == FULL) wdata_q <= req_wdata;
          end
        end
        CMD: begin
          if (cls_p0 == PART) begin
            state <= MERGE;
            cs_q  <= 1'b1;
            wen_q <= 1'b1;
          end else begin
            state <= RSP;
            cs_q  <= 1'b0;
            wen_q <= 1'b0;
          end
        end
        MERGE: begin
          state   <= RSP;
          cs_q    <= 1'b0;
          wen_q   <= 1'b0;
          wdata_q <= merged;
        end
        RSP: begin
          if (rsp_rdy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data only arrives the cycle after the read command, so the merge
  // result and the read response are steered from the SRAM port by state.
  assign sram_rw_mst.cs    = cs_q;
  assign sram_rw_mst.wen   = wen_q;
  assign sram_rw_mst.addr  = addr_q;
  assign sram_rw_mst.wdata = (state == MERGE) ? merged : wdata_q;

  assign req_rdy   = (state == IDLE);
  assign rsp_vld   = (state == RSP);
  assign rsp_rdata = (state == RSP && cls_p0 == RD) ? sram_rw_mst.rdata : '0;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a word SRAM model and a response scoreboard.
module tb_sram_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_vld;
  logic        req_rdy;
  logic [16:0] req_addr;
  logic        req_wen;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic [31:0] rsp_rdata;

  sram_rw_if_t #(.AW(15), .DW(32)) sif ();

  sram_ctrl #(.AW(15), .DW(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_vld     (req_vld),
    .req_rdy     (req_rdy),
    .req_addr    (req_addr),
    .req_wen     (req_wen),
    .req_wstrb   (req_wstrb),
    .req_wdata   (req_wdata),
    .rsp_vld     (rsp_vld),
    .rsp_rdy     (rsp_rdy),
    .rsp_rdata   (rsp_rdata),
    .sram_rw_mst (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: synchronous write, registered read data that holds otherwise
  logic [31:0] mem [0:32767];
  int          cs_cnt = 0;
  int          cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sif.cs) begin
      cs_cnt <= cs_cnt + 1;
      if (sif.wen) mem[sif.addr] <= sif.wdata;
      else         sif.rdata     <= mem[sif.addr];
    end
  end

  typedef struct {
    logic [31:0] rdata;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   seen  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compares every presented response against the scoreboard head
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_vld) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          if (!seen) begin
            seen = 1'b1;
            chk("rsp_latency", 32'(cyc + 1 - sb[0].acc), 32'(sb[0].lat));
          end
          chk("rsp_rdata", rsp_rdata, sb[0].rdata);
          if (rsp_rdy) begin
            void'(sb.pop_front());
            seen = 1'b0;
          end
        end
      end else begin
        chk("rsp_rdata_idle", rsp_rdata, 32'h0);
      end
    end
  end

  task automatic issue(input bit wen, input logic [16:0] addr, input logic [3:0] strb,
                       input logic [31:0] wd, input logic [31:0] exp, input int lat);
    int n;
    exp_t e;
    @(posedge clk); #1;
    req_vld = 1'b1; req_wen = wen; req_addr = addr; req_wstrb = strb; req_wdata = wd;
    n = 0;
    @(negedge clk);
    while (!req_rdy && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!req_rdy) chk("req_rdy_timeout", 32'd0, 32'd1);
    e.rdata = exp; e.acc = cyc + 1; e.lat = lat;
    sb.push_back(e);
    @(posedge clk); #1;
    req_vld = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (sb.size() != 0) chk("rsp_timeout", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req_rdy"}, 32'(req_rdy), 32'd1);
    chk({tag, "_rsp_vld"}, 32'(rsp_vld), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    chk({tag, "_cs"}, 32'(sif.cs), 32'd0);
    chk({tag, "_wen"}, 32'(sif.wen), 32'd0);
    chk({tag, "_addr"}, 32'(sif.addr), 32'h0);
    chk({tag, "_wdata"}, sif.wdata, 32'h0);
  endtask

  initial begin
    int          cs0;
    logic [31:0] held;
    int          n;
    req_vld = 1'b0; req_wen = 1'b0; req_addr = '0; req_wstrb = '0; req_wdata = '0;
    rsp_rdy = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 chk_reset_outs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Full write then read back
    cs0 = cs_cnt;
    issue(1'b1, 17'h0010, 4'hF, 32'hDEADBEEF, 32'h0, 2);
    wait_done();
    chk("full_cs_pulses", 32'(cs_cnt - cs0), 32'd1);
    chk("full_mem_word4", mem[4], 32'hDEADBEEF);
    issue(1'b0, 17'h0010, 4'h0, 32'h0, 32'hDEADBEEF, 2);
    wait_done();

    // Partial write: read-modify-write
    cs0 = cs_cnt;
    issue(1'b1, 17'h0010, 4'h5, 32'h11223344, 32'h0, 3);
    wait_done();
    chk("part_cs_pulses", 32'(cs_cnt - cs0), 32'd2);
    chk("part_mem_word4", mem[4], 32'hDE22BE44);
    issue(1'b0, 17'h0010, 4'h0, 32'h0, 32'hDE22BE44, 2);
    wait_done();

    // Back-pressure on a read
    @(posedge clk); #1 rsp_rdy = 1'b0;
    cs0 = cs_cnt;
    issue(1'b0, 17'h0010, 4'h0, 32'h0, 32'hDE22BE44, 2);
    n = 0;
    @(negedge clk);
    while (!rsp_vld && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("bp_rsp_vld_seen", 32'(rsp_vld), 32'd1);
    held = rsp_rdata;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_vld", 32'(rsp_vld), 32'd1);
      chk("bp_rdata_stable", rsp_rdata, held);
      chk("bp_req_rdy", 32'(req_rdy), 32'd0);
      chk("bp_cs", 32'(sif.cs), 32'd0);
      if (i < 4) @(negedge clk);
    end
    @(posedge clk); #1 rsp_rdy = 1'b1;
    @(negedge clk);
    chk("bp_hs_rsp_vld", 32'(rsp_vld), 32'd1);
    @(negedge clk);
    chk("bp_req_rdy_after", 32'(req_rdy), 32'd1);
    chk("bp_rsp_vld_after", 32'(rsp_vld), 32'd0);
    chk("bp_cs_pulses", 32'(cs_cnt - cs0), 32'd1);

    // NOP write leaves the word untouched
    issue(1'b1, 17'h0020, 4'hF, 32'hCAFEF00D, 32'h0, 2);
    wait_done();
    cs0 = cs_cnt;
    issue(1'b1, 17'h0020, 4'h0, 32'h12345678, 32'h0, 2);
    wait_done();
    chk("nop_cs_pulses", 32'(cs_cnt - cs0), 32'd0);
    chk("nop_mem_word8", mem[8], 32'hCAFEF00D);
    issue(1'b0, 17'h0020, 4'h0, 32'h0, 32'hCAFEF00D, 2);
    wait_done();

    // Unaligned byte address maps to the same word
    issue(1'b0, 17'h0013, 4'h0, 32'h0, 32'hDE22BE44, 2);
    wait_done();

    // Reset asserted during MERGE of a partial write
    issue(1'b1, 17'h0020, 4'h1, 32'h000000AA, 32'h0, 3);
    @(posedge clk); #2;
    chk("merge_cs", 32'(sif.cs), 32'd1);
    chk("merge_wen", 32'(sif.wen), 32'd1);
    rst_n = 1'b0;
    #1 chk_reset_outs("async_reset");
    sb.delete();
    seen = 1'b0;
    @(posedge clk); #3 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_req_rdy", 32'(req_rdy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("post_reset_rsp_vld", 32'(rsp_vld), 32'd0);
      @(negedge clk);
    end
    issue(1'b0, 17'h0010, 4'h0, 32'h0, 32'hDE22BE44, 2);
    wait_done();

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
